// File: rtl/counter_bus_setter.sv
// Controlling end of the half-duplex digit bus: tracks the counter while idle, takes the bus
// on request, lets the user edit the digit with auto-repeating inc/dec, then commits or restores.
module counter_bus_setter #(
    parameter int BASE           = 10,
    parameter int NUMBER_OF_BITS = 4,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_PERIOD  = 10_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      edit_req,
    input  logic                      inc,
    input  logic                      dec,
    input  logic                      commit,
    input  logic                      cancel,
    inout  wire  [NUMBER_OF_BITS-1:0] number,
    output logic                      set,
    output logic                      editing,
    output logic [NUMBER_OF_BITS-1:0] edit_value,
    output logic [NUMBER_OF_BITS-1:0] shadow,
    output logic                      done,
    output logic                      committed
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(REP_MAX + 1);
    localparam int NBP1    = NUMBER_OF_BITS + 1;
    localparam logic [NBP1-1:0]           BASE_W = NBP1'(BASE);
    localparam logic [NUMBER_OF_BITS-1:0] MAX_V  = NUMBER_OF_BITS'(BASE - 1);
    localparam logic [NUMBER_OF_BITS-1:0] ZERO_V = {NUMBER_OF_BITS{1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TURN_ON  = 3'd1,
        ST_EDIT     = 3'd2,
        ST_FINAL    = 3'd3,
        ST_TURN_OFF = 3'd4
    } state_t;

    state_t                    state_r;
    logic                      drv_en_r;
    logic [NUMBER_OF_BITS-1:0] drive_value_r;
    logic [NUMBER_OF_BITS-1:0] orig_r;
    logic                      commit_pend_r;
    logic                      inc_q_r;
    logic                      dec_q_r;
    logic                      rep_active_r;
    logic                      rep_phase_r;
    logic [CNT_W-1:0]          rep_cnt_r;

    logic                      single_s;
    logic                      step_s;
    logic                      rep_active_s;
    logic                      rep_phase_s;
    logic [CNT_W-1:0]          rep_cnt_s;
    logic [NUMBER_OF_BITS-1:0] step_value_s;

    function automatic logic [NUMBER_OF_BITS-1:0] wrap_inc(input logic [NUMBER_OF_BITS-1:0] v);
        wrap_inc = (v == MAX_V) ? ZERO_V : v + NUMBER_OF_BITS'(1);
    endfunction

    function automatic logic [NUMBER_OF_BITS-1:0] wrap_dec(input logic [NUMBER_OF_BITS-1:0] v);
        wrap_dec = (v == ZERO_V) ? MAX_V : v - NUMBER_OF_BITS'(1);
    endfunction

    // Only registered values reach the bus, so ownership changes are glitch-free.
    assign number = drv_en_r ? drive_value_r : {NUMBER_OF_BITS{1'bz}};

    // Press/auto-repeat decision; a hold only repeats if it began as a fresh press in EDIT.
    always_comb begin
        single_s     = inc ^ dec;
        step_s       = 1'b0;
        rep_active_s = 1'b0;
        rep_phase_s  = 1'b0;
        rep_cnt_s    = {CNT_W{1'b0}};
        if (single_s) begin
            if ((inc != inc_q_r) || (dec != dec_q_r)) begin
                step_s       = 1'b1;
                rep_active_s = 1'b1;
                rep_cnt_s    = CNT_W'(1);
            end else if (!rep_active_r) begin
                rep_active_s = 1'b0;
            end else if (!rep_phase_r) begin
                rep_active_s = 1'b1;
                if (rep_cnt_r == CNT_W'(REPEAT_DELAY)) begin
                    step_s      = 1'b1;
                    rep_phase_s = 1'b1;
                    rep_cnt_s   = CNT_W'(1);
                end else begin
                    rep_cnt_s   = rep_cnt_r + CNT_W'(1);
                end
            end else begin
                rep_active_s = 1'b1;
                rep_phase_s  = 1'b1;
                if (rep_cnt_r == CNT_W'(REPEAT_PERIOD)) begin
                    step_s    = 1'b1;
                    rep_cnt_s = CNT_W'(1);
                end else begin
                    rep_cnt_s = rep_cnt_r + CNT_W'(1);
                end
            end
        end else begin
            rep_active_s = 1'b0;
        end
        if (step_s) begin
            step_value_s = inc ? wrap_inc(edit_value) : wrap_dec(edit_value);
        end else begin
            step_value_s = edit_value;
        end
    end

    // Session FSM with all bus-control and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            set           <= 1'b0;
            drv_en_r      <= 1'b0;
            editing       <= 1'b0;
            done          <= 1'b0;
            committed     <= 1'b0;
            edit_value    <= ZERO_V;
            shadow        <= ZERO_V;
            orig_r        <= ZERO_V;
            drive_value_r <= ZERO_V;
            commit_pend_r <= 1'b0;
            inc_q_r       <= 1'b0;
            dec_q_r       <= 1'b0;
            rep_active_r  <= 1'b0;
            rep_phase_r   <= 1'b0;
            rep_cnt_r     <= {CNT_W{1'b0}};
        end else begin
            done         <= 1'b0;
            committed    <= 1'b0;
            // History follows the buttons everywhere, so a button held on entry is not a press.
            inc_q_r      <= inc;
            dec_q_r      <= dec;
            rep_active_r <= 1'b0;
            rep_phase_r  <= 1'b0;
            rep_cnt_r    <= {CNT_W{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    set      <= 1'b0;
                    drv_en_r <= 1'b0;
                    editing  <= 1'b0;
                    shadow   <= number;
                    if (edit_req) begin
                        orig_r     <= number;
                        edit_value <= ({1'b0, number} < BASE_W) ? number : ZERO_V;
                        set        <= 1'b1;
                        editing    <= 1'b1;
                        state_r    <= ST_TURN_ON;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TURN_ON: begin
                    drv_en_r      <= 1'b1;
                    drive_value_r <= edit_value;
                    state_r       <= ST_EDIT;
                end
                ST_EDIT: begin
                    if (cancel) begin
                        drive_value_r <= orig_r;
                        commit_pend_r <= 1'b0;
                        state_r       <= ST_FINAL;
                    end else if (commit) begin
                        drive_value_r <= edit_value;
                        commit_pend_r <= 1'b1;
                        state_r       <= ST_FINAL;
                    end else begin
                        edit_value    <= step_value_s;
                        drive_value_r <= step_value_s;
                        rep_active_r  <= rep_active_s;
                        rep_phase_r   <= rep_phase_s;
                        rep_cnt_r     <= rep_cnt_s;
                        state_r       <= ST_EDIT;
                    end
                end
                ST_FINAL: begin
                    drv_en_r <= 1'b0;
                    state_r  <= ST_TURN_OFF;
                end
                ST_TURN_OFF: begin
                    set       <= 1'b0;
                    editing   <= 1'b0;
                    done      <= 1'b1;
                    committed <= commit_pend_r;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    set      <= 1'b0;
                    drv_en_r <= 1'b0;
                    editing  <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
